// File: rtl/ps2_key_receiver_pkg.sv
// Shared definitions for the PS/2 key receiver: FSM encodings,
// frame bit positions and the parity helper.
package ps2_key_receiver_pkg;

  localparam int FRAME_W = 11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  localparam int BIT_START  = 0;
  localparam int BIT_PARITY = 9;
  localparam int BIT_STOP   = 10;

  // Odd parity over data[7:0] plus the parity bit.
  function automatic logic parity_ok(input logic [8:0] pd);
    return ^pd;
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// First-word fall-through frame FIFO with sticky overflow flag;
// output reads as zero while empty.
module ps2_key_fifo
  import ps2_key_receiver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [FRAME_W-1:0] data_i,
  input  logic               pop_i,
  output logic [FRAME_W-1:0] data_o,
  output logic               ready_o,
  output logic               overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q;
  logic [AW-1:0]      rd_q;
  logic [AW:0]        cnt_q;
  logic               ovf_q;
  logic               empty;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - (AW+1)'(1);
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o     = empty ? '0 : mem_q[rd_q];
  assign ready_o    = ~empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: synchronizers, clock glitch filter,
// frame FSM with timeout, and a FIFO of received frames.
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iKeyboard_Clock,
  input  logic        iKeyboard_Data,
  output logic [10:0] oKey_Data_Out,
  output logic        oData_Ready,
  input  logic        iData_Received,
  output logic        oParityError,
  output logic        oFrameError,
  output logic        oOverflow
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic               kc_s1_q, kc_s2_q;
  logic               kd_s1_q, kd_s2_q;
  logic               filt_q, fall_q;
  logic [FW-1:0]      fcnt_q;
  logic [1:0]         state_q, state_d;
  logic [3:0]         bcnt_q, bcnt_d;
  logic [TW-1:0]      to_q, to_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               ack_q;
  logic               push;
  logic               pop;
  logic               start_stop_ok;
  logic               par_ok;

  // Lines idle high, so synchronizers and filter reset to 1.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      kc_s1_q <= 1'b1;
      kc_s2_q <= 1'b1;
      kd_s1_q <= 1'b1;
      kd_s2_q <= 1'b1;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
    end else begin
      kc_s1_q <= iKeyboard_Clock;
      kc_s2_q <= kc_s1_q;
      kd_s1_q <= iKeyboard_Data;
      kd_s2_q <= kd_s1_q;
      fall_q  <= 1'b0;
      if (kc_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= kc_s2_q;
        fcnt_q <= '0;
        fall_q <= filt_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign start_stop_ok = ~sr_q[BIT_START] & sr_q[BIT_STOP];
  assign par_ok        = parity_ok(sr_q[BIT_PARITY:1]);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    sr_d    = sr_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall_q && !kd_s2_q) begin
          sr_d    = {kd_s2_q, sr_q[FRAME_W-1:1]};
          bcnt_d  = 4'd1;
          to_d    = '0;
          state_d = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (fall_q) begin
          sr_d   = {kd_s2_q, sr_q[FRAME_W-1:1]};
          bcnt_d = bcnt_q + 4'd1;
          to_d   = '0;
          if (bcnt_q == 4'd10) state_d = ST_CHECK;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d  = 1'b1;
          bcnt_d  = '0;
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_CHECK: begin
        push    = start_stop_ok & par_ok;
        perr_d  = ~par_ok;
        ferr_d  = ~start_stop_ok;
        bcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      to_q    <= '0;
      sr_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
      sr_q    <= sr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ack_q   <= iData_Received;
    end
  end

  assign pop = iData_Received & ~ack_q & oData_Ready;

  ps2_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .push_i    (push),
    .data_i    (sr_q),
    .pop_i     (pop),
    .data_o    (oKey_Data_Out),
    .ready_o   (oData_Ready),
    .overflow_o(oOverflow)
  );

  assign oParityError = perr_q;
  assign oFrameError  = ferr_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: frame vectors,
// latency, glitch, timeout, overflow and mid-frame reset.
module tb_ps2_key_receiver;

  localparam int F  = 8;
  localparam int T  = 300;
  localparam int D  = 4;
  localparam int HB = 20;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        kclk = 1'b1;
  logic        kdat = 1'b1;
  logic        ack  = 1'b0;
  logic [10:0] kout;
  logic        rdy, perr, ferr, ovf;

  always #5 clk = ~clk;

  ps2_key_receiver #(
    .FILTER_LEN    (F),
    .TIMEOUT_CYCLES(T),
    .FIFO_DEPTH    (D)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .iKeyboard_Clock(kclk),
    .iKeyboard_Data(kdat),
    .oKey_Data_Out (kout),
    .oData_Ready   (rdy),
    .iData_Received(ack),
    .oParityError  (perr),
    .oFrameError   (ferr),
    .oOverflow     (ovf)
  );

  int checks   = 0;
  int failures = 0;
  int perr_n   = 0;
  int ferr_n   = 0;
  logic [10:0] sbq[$];

  typedef struct {
    logic [7:0]  scan;
    logic        par;
    logic        stop;
    logic        exp_rdy;
    int          exp_perr;
    int          exp_ferr;
    logic [10:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if (perr) perr_n++;
    if (ferr) ferr_n++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mkf(logic [7:0] s, logic p, logic st);
    return {st, p, s, 1'b0};
  endfunction

  task automatic send_bit(logic b);
    kdat = b;
    cyc(HB);
    kclk = 1'b0;
    cyc(HB);
    kclk = 1'b1;
  endtask

  task automatic send_bits(logic [10:0] f, int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  task automatic send_frame(logic [10:0] f);
    send_bits(f, 11);
    kdat = 1'b1;
    cyc(HB);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(2);
  endtask

  task automatic chk_head(string nm);
    logic [10:0] e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_expected required=queued_frame", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_rdy"}, rdy, 1);
      chk({nm, "_data"}, kout, e);
    end
  endtask

  task automatic chk_idle_outs(string nm);
    chk({nm, "_rdy"}, rdy, 0);
    chk({nm, "_data"}, kout, 0);
    chk({nm, "_perr"}, perr, 0);
    chk({nm, "_ferr"}, ferr, 0);
    chk({nm, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int p0, f0, n;
    logic seen;
    logic [7:0] s;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0, 11'h438};
    vecs[1] = '{8'h1D, 1'b0, 1'b1, 1'b0, 1, 0, 11'h000};
    vecs[2] = '{8'h23, 1'b0, 1'b1, 1'b1, 0, 0, 11'h446};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 0, 0, 11'h6B4};
    vecs[4] = '{8'hF0, 1'b1, 1'b0, 1'b0, 0, 1, 11'h000};
    vecs[5] = '{8'h1D, 1'b0, 1'b0, 1'b0, 1, 1, 11'h000};

    cyc(3);
    chk_idle_outs("reset");
    rst = 1'b0;
    cyc(HB);

    // Stop-bit latency: 2 sync + F filter + CHECK + push register.
    p0 = perr_n;
    f0 = ferr_n;
    sbq.push_back(11'h438);
    send_bits(mkf(8'h1C, 1'b0, 1'b1), 10);
    kdat = 1'b1;
    cyc(HB);
    kclk = 1'b0;
    cyc(F + 3);
    chk("lat_early_rdy", rdy, 0);
    cyc(1);
    chk_head("lat_frame");
    cyc(HB);
    kclk = 1'b1;
    cyc(HB);
    chk("lat_perr", perr_n - p0, 0);
    chk("lat_ferr", ferr_n - f0, 0);
    ack_pulse();
    chk("lat_pop_rdy", rdy, 0);

    for (int i = 0; i < 6; i++) begin
      p0 = perr_n;
      f0 = ferr_n;
      if (vecs[i].exp_rdy) sbq.push_back(vecs[i].exp_data);
      send_frame(mkf(vecs[i].scan, vecs[i].par, vecs[i].stop));
      chk($sformatf("vec%0d_perr", i), perr_n - p0, vecs[i].exp_perr);
      chk($sformatf("vec%0d_ferr", i), ferr_n - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
      if (vecs[i].exp_rdy) begin
        chk_head($sformatf("vec%0d_head", i));
        ack_pulse();
        chk($sformatf("vec%0d_pop", i), rdy, 0);
      end
    end

    p0 = perr_n;
    f0 = ferr_n;
    kclk = 1'b0;
    cyc(3);
    kclk = 1'b1;
    cyc(30);
    chk("glitch_rdy", rdy, 0);
    chk("glitch_data", kout, 0);
    chk("glitch_perr", perr_n - p0, 0);
    chk("glitch_ferr", ferr_n - f0, 0);

    // Timeout measured from the raw falling edge of the 5th bit.
    f0 = ferr_n;
    seen = 1'b0;
    n = 0;
    send_bits(mkf(8'h1C, 1'b0, 1'b1), 4);
    kdat = 1'b0;
    cyc(HB);
    kclk = 1'b0;
    for (int k = 1; k <= T + F + 20; k++) begin
      cyc(1);
      if (k == HB) kclk = 1'b1;
      if (ferr && !seen) begin
        seen = 1'b1;
        n = k;
      end
    end
    kdat = 1'b1;
    chk("to_seen", seen, 1);
    chk("to_window", (n >= T + F + 2) && (n <= T + F + 4), 1);
    chk("to_ferr_count", ferr_n - f0, 1);
    chk("to_rdy", rdy, 0);
    cyc(HB);
    sbq.push_back(11'h446);
    send_frame(mkf(8'h23, 1'b0, 1'b1));
    chk_head("to_next");
    ack_pulse();

    for (int i = 1; i <= 5; i++) begin
      s = 8'(i);
      if (i <= D) sbq.push_back(mkf(s, ~^s, 1'b1));
      send_frame(mkf(s, ~^s, 1'b1));
    end
    chk("ovf_flag", ovf, 1);
    for (int i = 0; i < D; i++) begin
      chk_head($sformatf("ovf_head%0d", i));
      ack_pulse();
    end
    chk("ovf_drain_rdy", rdy, 0);
    chk("ovf_drain_data", kout, 0);
    ack_pulse();
    chk("empty_pop_rdy", rdy, 0);
    chk("ovf_sticky", ovf, 1);

    p0 = perr_n;
    f0 = ferr_n;
    send_bits(mkf(8'h1C, 1'b0, 1'b1), 6);
    rst = 1'b1;
    cyc(2);
    chk_idle_outs("midrst");
    rst = 1'b0;
    cyc(HB);
    chk("midrst_perr", perr_n - p0, 0);
    chk("midrst_ferr", ferr_n - f0, 0);
    sbq.push_back(11'h438);
    send_frame(mkf(8'h1C, 1'b0, 1'b1));
    chk_head("midrst_next");
    ack_pulse();

    sbq.push_back(11'h438);
    sbq.push_back(11'h446);
    send_frame(mkf(8'h1C, 1'b0, 1'b1));
    send_frame(mkf(8'h23, 1'b0, 1'b1));
    ack = 1'b1;
    cyc(6);
    ack = 1'b0;
    cyc(2);
    void'(sbq.pop_front());
    chk_head("held_ack");
    ack_pulse();
    chk("held_ack_empty", rdy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
